// File: rtl/tff_down_timer_if.sv
// Control and status bundle for tff_down_timer: count/load controls in,
// registered count, busy and done out.
interface tff_down_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             T;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             RELOAD;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic             DONE;

  modport master (
    output T, LOAD, D, RELOAD,
    input  Q, BUSY, DONE
  );

  modport slave (
    input  T, LOAD, D, RELOAD,
    output Q, BUSY, DONE
  );
endinterface

// File: rtl/tff_down_timer.sv
// Loadable falling-edge down counter/timer with one-shot or auto-reload mode.
// Define TFF_DOWN_TIMER_STICKY_DONE_EN to hold DONE until the next LOAD/RESET.
module tff_down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  tff_down_timer_if.slave    bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] r, r_n;
  logic             done, done_n;

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      r     <= r_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    r_n     = r;
`ifdef TFF_DOWN_TIMER_STICKY_DONE_EN
    done_n  = done;
`else
    done_n  = 1'b0;
`endif
    if (bus.LOAD) begin
      // A load wins even on the terminal edge, so no DONE is raised there.
      q_n    = bus.D;
      r_n    = bus.D;
      done_n = (bus.D == '0);
      if (bus.D != '0) begin
        state_n = RUN;
      end else begin
        state_n = IDLE;
      end
    end else if (state == RUN && bus.T) begin
      if (q == ONE) begin
        done_n = 1'b1;
        if (bus.RELOAD) begin
          q_n = r;
        end else begin
          q_n     = '0;
          state_n = IDLE;
        end
      end else if (q > ONE) begin
        q_n = q - ONE;
      end
    end
  end

  // BUSY comes straight from the state flop, so it is registered.
  assign bus.Q    = q;
  assign bus.BUSY = (state == RUN);
  assign bus.DONE = done;

endmodule

// File: tb/tb_tff_down_timer.sv
// Self-checking bench for tff_down_timer: directed timing cases plus a
// randomized run compared against a behavioural countdown model.
module tb_tff_down_timer;

`ifdef TFF_DOWN_TIMER_STICKY_DONE_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tff_down_timer_if #(.WIDTH(4)) bus ();

  tff_down_timer #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Model: remaining count, reload value, whether a countdown is active.
  logic [3:0] m_left, m_period;
  bit         m_active, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_period = 0; m_active = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit t, input bit ld, input logic [3:0] d, input bit rl);
    bit expired;
    if (ld) begin
      m_left = d; m_period = d; m_active = (d != 0); m_done = (d == 0);
    end else begin
      expired = m_active && t && (m_left == 1);
      if (m_active && t) begin
        if (!expired) m_left = m_left - 1;
        else if (rl) m_left = m_period;
        else begin m_left = 0; m_active = 0; end
      end
      m_done = expired || (STICKY && m_done);
    end
  endtask

  task automatic tick(input bit t, input bit ld, input logic [3:0] d, input bit rl);
    RESET = 1'b0;
    bus.T = t; bus.LOAD = ld; bus.D = d; bus.RELOAD = rl;
    @(negedge CLK);
    #1;
    model_edge(t, ld, d, rl);
    bus.LOAD = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, bus.Q, m_left);
    check({tag, "_busy"}, bus.BUSY, m_active);
    check({tag, "_done"}, bus.DONE, m_done);
  endtask

  logic [3:0] aq [11] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd3};
  bit         at [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
  bit         ad [11] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.T = 0; bus.LOAD = 0; bus.D = 0; bus.RELOAD = 0;
    model_reset();
    #2 RESET = 1'b1;
    #1;
    check("rst_q", bus.Q, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    @(negedge CLK); #1;

    // One-shot D=4: Q=4-j after edge j, DONE only at edge 4.
    tick(1, 1, 4'd4, 0);
    check("os_load_q", bus.Q, 4);
    check("os_load_busy", bus.BUSY, 1);
    check("os_load_done", bus.DONE, 0);
    for (int j = 1; j <= 6; j++) begin
      tick(1, 0, 4'd0, 0);
      check("os_q", bus.Q, (j <= 4) ? 4 - j : 0);
      check("os_busy", bus.BUSY, j < 4);
      check("os_done", bus.DONE, STICKY ? (j >= 4) : (j == 4));
    end

    // Auto-reload D=3 with a two-edge pause.
    tick(1, 1, 4'd3, 1);
    check("ar_load_q", bus.Q, 3);
    for (int i = 0; i < 11; i++) begin
      tick(at[i], 0, 4'd0, 1);
      check("ar_q", bus.Q, aq[i]);
      check("ar_busy", bus.BUSY, 1);
      check("ar_done", bus.DONE, STICKY ? (i >= 2) : ad[i]);
    end

    // Zero-length timer.
    tick(1, 1, 4'd0, 0);
    check("z_q", bus.Q, 0);
    check("z_busy", bus.BUSY, 0);
    check("z_done", bus.DONE, 1);
    tick(1, 0, 4'd0, 0);
    check("z_done_next", bus.DONE, STICKY);
    check("z_q_next", bus.Q, 0);

    // Full-scale D=15: 15 enabled edges to DONE.
    tick(1, 1, 4'd15, 0);
    for (int j = 1; j <= 15; j++) begin
      tick(1, 0, 4'd0, 0);
      check("f_q", bus.Q, 15 - j);
      check("f_done", bus.DONE, j == 15);
    end
    check("f_busy_end", bus.BUSY, 0);

    // LOAD on the terminal edge wins.
    tick(1, 1, 4'd2, 0);
    tick(1, 0, 4'd0, 0);
    check("te_pre_q", bus.Q, 1);
    tick(1, 1, 4'd9, 0);
    check("te_q", bus.Q, 9);
    check("te_busy", bus.BUSY, 1);
    check("te_done", bus.DONE, 0);

    // Asynchronous reset mid-run at Q=5.
    tick(1, 1, 4'd8, 0);
    for (int j = 0; j < 3; j++) tick(1, 0, 4'd0, 0);
    check("mr_pre_q", bus.Q, 5);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check("mr_q", bus.Q, 0);
    check("mr_busy", bus.BUSY, 0);
    check("mr_done", bus.DONE, 0);
    @(negedge CLK); #1;
    check("mr_hold_q", bus.Q, 0);

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      bit         rt, rl, rld;
      logic [3:0] rd;
      rt  = ($urandom_range(0, 3) != 0);
      rld = ($urandom_range(0, 11) == 0);
      rd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      rl  = $urandom_range(0, 1);
      tick(rt, rld, rd, rl);
      check_model("rnd");
      if ($urandom_range(0, 99) == 0) begin
        #2 RESET = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_down_timer.md
# tff_down_timer

Loadable, falling-edge-clocked down counter/timer that complements the up-counting ripple counter: where the up counter counts events from zero, this block counts a loaded value down to zero and flags completion. It serves as the countdown/interval element next to the ripple counters, in one-shot or auto-reload mode. All state updates occur on the falling edge of CLK, matching the existing counters.

## Interface
- WIDTH, 4, counter width in bits (≥2).
- CLK  input  1  clock; all state changes on the falling edge.
- RESET  input  1  asynchronous, active-high reset.
- T  input  1  count enable; decrement on a falling edge only when T=1.
- LOAD  input  1  load request; sampled on a falling edge.
- D  input  WIDTH  load value, captured with LOAD.
- RELOAD  input  1  auto-reload mode select, sampled at the terminal edge.
- Q  output  WIDTH  current count (registered).
- BUSY  output  1  high while in RUN (registered).
- DONE  output  1  completion flag (registered).

## Operation
- Internal reload register R (WIDTH bits). States: IDLE, RUN.
- RESET=1, asynchronous: Q=0, R=0, BUSY=0, DONE=0, state IDLE. Effect is immediate and holds while RESET is high, including mid-RUN.
- Priority at each falling edge: LOAD > terminal count > decrement > hold.
- LOAD=1 in either state: Q←D, R←D, DONE←0.
  - D≠0: go to RUN, BUSY←1.
  - D=0: stay in or go to IDLE, BUSY←0, DONE←1. This is a zero-length timer.
- RUN with T=0 and LOAD=0: Q, BUSY and DONE hold, except that a DONE pulse clears (see below).
- RUN with T=1, LOAD=0, Q>1: Q←Q−1.
- RUN with T=1, LOAD=0, Q=1 (terminal edge): DONE←1, then
  - RELOAD=0: Q←0, go to IDLE, BUSY←0.
  - RELOAD=1: Q←R, stay in RUN.
- IDLE with LOAD=0: Q holds and T is ignored. There is no wrap below zero.
- DONE is a one-cycle pulse: it clears on the next falling edge unless that edge re-asserts it.
- No arithmetic wrap can occur, because Q never decrements from 0.

## Timing
- LOAD at falling edge k with D=N≥1 and T held high:
  - Q=N and BUSY=1 after edge k.
  - Q=N−j after edge k+j.
  - DONE=1 from edge k+N to edge k+N+1.
- In one-shot mode (RELOAD=0), BUSY falls at edge k+N.
- In auto-reload mode (RELOAD=1), Q runs N, N−1, …, 1, N, … and DONE pulses every N enabled edges.
- LOAD on the terminal edge: the load wins and DONE is not asserted.
- T=0 cycles stretch the countdown one-for-one.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: TFF_DOWN_TIMER_STICKY_DONE_EN.
- Defined: DONE is sticky. Once set, it stays 1 until the next LOAD or RESET, including across auto-reload periods.
- Undefined (default): DONE is a one-cycle pulse as described in Operation.

## Test plan
- Reset: assert RESET mid-RUN at Q=5 → Q=0, BUSY=0, DONE=0 immediately, without waiting for a clock edge.
- One-shot: WIDTH=4, LOAD D=4, RELOAD=0, T=1 → Q 4,3,2,1,0 on successive falling edges. DONE=1 for exactly one cycle as Q reaches 0, then BUSY=0 and Q stays 0 with T=1.
- Auto-reload and pause: LOAD D=3, RELOAD=1 → Q 3,2,1,3,2,1 with a DONE pulse at each 1→3 transition. Dropping T for 2 cycles holds Q and delays the next DONE by 2 cycles.
- Boundaries:
  - LOAD D=0 → Q=0, BUSY=0, DONE pulse for one cycle.
  - LOAD D=15 → 15 enabled edges to DONE.
  - LOAD D=9 asserted on the terminal edge → Q=9, no DONE.
- Sticky variant: with TFF_DOWN_TIMER_STICKY_DONE_EN defined, LOAD D=2, RELOAD=1 → DONE goes to 1 at the first terminal edge and stays 1 until the next LOAD clears it.
